// File: rtl/ps2_rx_apb_fifo.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM, byte FIFO and APB registers.
// Optional build macro PS2_RX_TIMEOUT_EN aborts stalled frames after TIMEOUT_CYCLES idle cycles.
module ps2_rx_apb_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   filt_q, filt_d;
  logic                   clk_s, data_s, strobe;

  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   push, perr_set, ferr_set, to_abort;

  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   nonempty, full, pop, fifo_we, flush, ovf_set;

  logic                   ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                   en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;

  logic                   access, wr_status, wr_ctrl;
  logic [1:0]             addr;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    // The filtered clock only follows a run of FILTER_LEN samples that disagree with it.
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_s;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign strobe = filt_q & ~filt_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    to_abort = 1'b0;
    if (state_q == S_IDLE || strobe) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_abort = 1'b1;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign to_abort       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    push      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    if (!en_q) begin
      state_d = S_IDLE;
    end else if (to_abort) begin
      state_d  = S_IDLE;
      ferr_set = 1'b1;
    end else if (strobe) begin
      case (state_q)
        S_IDLE: if (!data_s) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
        S_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_s;
          state_d  = S_STOP;
        end
        default: begin
          push     = data_s & (^{shift_q, parity_q});
          ferr_set = ~data_s;
          perr_set = ~(^{shift_q, parity_q});
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  assign access    = in_psel & in_penable;
  assign addr      = in_paddr[3:2];
  assign wr_status = access & in_pwrite & (addr == A_STATUS) & in_pstrb[0];
  assign wr_ctrl   = access & in_pwrite & (addr == A_CTRL) & in_pstrb[0];
  assign nonempty  = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = access & ~in_pwrite & (addr == A_DATA) & nonempty;
  assign flush     = wr_ctrl & in_pwdata[2];
  assign fifo_we   = push & (~full | pop) & ~flush;
  assign ovf_set   = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_we) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (fifo_we && !pop)      count_d = count_q + 1'b1;
      else if (!fifo_we && pop) count_d = count_q - 1'b1;
    end
  end

  // A new set outranks a same-cycle W1C of the same flag.
  always_comb begin
    ovf_d    = ovf_set  | (ovf_q  & ~(wr_status & in_pwdata[2]));
    perr_d   = perr_set | (perr_q & ~(wr_status & in_pwdata[3]));
    ferr_d   = ferr_set | (ferr_q & ~(wr_status & in_pwdata[4]));
    en_d     = wr_ctrl ? in_pwdata[0] : en_q;
    irq_en_d = wr_ctrl ? in_pwdata[1] : irq_en_q;
    irq_d    = irq_en_q & (nonempty | ovf_q | perr_q | ferr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      en_q        <= 1'b1;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      en_q        <= en_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (fifo_we) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    in_prdata = '0;
    if (access && !in_pwrite) begin
      case (addr)
        A_DATA:   if (nonempty) in_prdata = {23'b0, 1'b1, mem_q[rd_ptr_q]};
        A_STATUS: begin
          in_prdata[4:0]       = {ferr_q, perr_q, ovf_q, full, nonempty};
          in_prdata[5 +: CNT_W] = count_q;
        end
        A_CTRL:   in_prdata[1:0] = {irq_en_q, en_q};
        default:  in_prdata = '0;
      endcase
    end
  end

  assign in_pslverr = access & (((addr == A_DATA) & in_pwrite) | (addr == A_RSVD));
  assign in_pready  = 1'b1;
  assign irq        = irq_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, in_pprot, in_paddr[31:4], in_paddr[1:0],
                       in_pwdata[31:5], in_pstrb[3:1]};

endmodule

// File: doc/ps2_rx_apb_fifo.md
Name: ps2_rx_apb_fifo

Overview:
Parametrised PS/2 keyboard receiver with an APB slave interface, the next generation of the single-register PS/2 port.
- Synchronises and glitch-filters ps2_clk, decodes 11-bit frames, and buffers good bytes in a configurable FIFO.
- Exposes DATA/STATUS/CTRL registers, sticky error flags and a level interrupt.
- Sits on the APB peripheral crossbar and is read by firmware polling or IRQ handlers.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of two, at least 2.
SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data; at least 2.
FILTER_LEN, 4, consecutive identical synced ps2_clk samples required before the filtered clock changes.
TIMEOUT_CYCLES, 50000, idle clock cycles mid-frame before abort (optional feature only).

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
in_paddr  in  32  APB address; only [3:2] decoded.
in_psel  in  1  APB select.
in_penable  in  1  APB access phase.
in_pprot  in  3  ignored.
in_pwrite  in  1  1 = write.
in_pwdata  in  32  write data.
in_pstrb  in  4  byte strobes; only [0] used.
in_pready  out  1  constant 1 (zero wait states).
in_prdata  out  32  read data.
in_pslverr  out  1  error response.
ps2_clk  in  1  asynchronous PS/2 clock.
ps2_data  in  1  asynchronous PS/2 data.
irq  out  1  level interrupt.

Behaviour:
- Reset values (async, active-low):
  - FIFO empty; FSM IDLE; flags 0; CTRL.EN=1, CTRL.IRQ_EN=0.
  - Filtered clock = 1.
  - Outputs: irq=0, in_prdata=0, in_pslverr=0, in_pready=1.
- Input path:
  - Both PS/2 inputs pass through SYNC_STAGES flops.
  - The filtered clock takes the synced value after FILTER_LEN consecutive equal samples.
  - A 1→0 transition of the filtered clock is the sample strobe (one cycle); the synced ps2_data is sampled on that cycle.
- Frame FSM (advances only on strobe while EN=1):
  - IDLE: data=0 → DATA (bit index 0); data=1 → stay in IDLE.
  - DATA: shift in LSB first; after bit 7 → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop=1 and data+parity has odd parity → push byte; stop=0 → set FERR; parity bad → set PERR (both set if both bad). Always → IDLE.
- EN=0: FSM forced to IDLE immediately; a partial frame is discarded without a flag; the FIFO is retained.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
  - Push while full with no pop in the same cycle: byte dropped, OVF set, contents unchanged.
  - Push and pop in the same cycle: both occur and count is unchanged (also when full).
- Register map (access phase = psel & penable):
  - 0x0 DATA, RO:
    - Read nonempty: {23'b0, 1'b1, head byte}, then pop.
    - Read empty: 0, no pop.
    - Write: pslverr=1, no effect.
  - 0x4 STATUS: [0] nonempty, [1] full, [2] OVF, [3] PERR, [4] FERR, [5 +: count width] count.
    - Writing with pstrb[0]=1 clears each of bits [4:2] written as 1 (W1C).
  - 0x8 CTRL: [0] EN, [1] IRQ_EN, [2] FLUSH.
    - FLUSH write: empties the FIFO next cycle; reads back 0.
    - A write with pstrb[0]=0 is ignored.
  - 0xC: pslverr=1; reads return 0.
- in_prdata is combinational during the access phase and 0 otherwise; pslverr is asserted only during the access phase.
- irq = IRQ_EN & (nonempty | OVF | PERR | FERR); registered, one cycle behind the flags.
- A flag set and a W1C clear of the same flag in the same cycle: set wins.

Optional Feature:
PS2_RX_TIMEOUT_EN:
- Defined: a counter reloads on every strobe and whenever the FSM is IDLE. If the FSM is not IDLE and TIMEOUT_CYCLES cycles pass with no strobe, the FSM aborts to IDLE and sets FERR.
- Undefined: no counter; a partial frame waits indefinitely.

Test Plan:
- Send frame byte 0x1C with odd parity 0 and stop 1 → STATUS.nonempty=1, count=1; DATA read returns 0x11C; next DATA read returns 0x000.
- Send 9 valid bytes 0x01..0x09 with FIFO_DEPTH=8 → full=1, OVF=1; eight reads return 0x01..0x08; write 0x4 to STATUS → OVF=0.
- Send 0x55 with wrong parity, then 0x66 with stop=0 → no push; PERR=1, FERR=1; with IRQ_EN=1, irq=1 until both are cleared by W1C.
- Inject 2-cycle low glitches on ps2_clk between real edges (FILTER_LEN=4) → no extra strobes; byte 0xA5 is received correctly.
- Frame strobe arrives on the same cycle as a DATA read with the FIFO full → popped head returned, new byte accepted, count stays 8, OVF=0.
- PS2_RX_TIMEOUT_EN with TIMEOUT_CYCLES=100: send 4 bits then idle 100 cycles → FERR=1, FSM IDLE; next full frame 0x3A is received correctly. Also drive reset=0 mid-frame → all state cleared, irq=0.
